// File: rtl/fir_avl_decim.sv
// Packet-aware Avalon-ST FIR decimator: forwards header words, filters
// payload with a single time-multiplexed MAC, closes with a status trailer.
module fir_avl_decim #(
    parameter int DATA_WIDTH   = 16,
    parameter int COEF_WIDTH   = 18,
    parameter int FRAC_BITS    = 16,
    parameter int NUM_TAPS     = 21,
    parameter int DECIM        = 2,
    parameter int HEADER_WORDS = 3,
    parameter logic [NUM_TAPS*COEF_WIDTH-1:0] COEFS = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  data_input_ready,
    input  logic                  data_input_valid,
    input  logic                  data_input_startofpacket,
    input  logic                  data_input_endofpacket,
    input  logic [DATA_WIDTH-1:0] data_input_data,
    input  logic                  data_output_ready,
    output logic                  data_output_valid,
    output logic                  data_output_startofpacket,
    output logic                  data_output_endofpacket,
    output logic [DATA_WIDTH-1:0] data_output_data
);
    localparam int KW  = $clog2(NUM_TAPS);
    localparam int PW  = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int HW  = $clog2(HEADER_WORDS + 1);
    localparam int PRW = DATA_WIDTH + COEF_WIDTH;
    localparam int ACW = PRW + KW;

    localparam logic signed [ACW-1:0] SMAX =
        {{(ACW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACW-1:0] SMIN =
        {{(ACW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        MAC,
        EMIT
    } state_t;

    state_t                        state;
    logic                          live;
    logic                          sat;
    logic [KW-1:0]                 k;
    logic [PW-1:0]                 phase;
    logic [HW-1:0]                 hcnt;
    logic signed [ACW-1:0]         acc;
    logic signed [DATA_WIDTH-1:0]  x [NUM_TAPS];
    logic signed [COEF_WIDTH-1:0]  h [NUM_TAPS];
    logic signed [PRW-1:0]         prod;
    logic signed [ACW-1:0]         shifted;
    logic [DATA_WIDTH-1:0]         result;
    logic                          clip;
    logic                          out_free;
    logic                          accept;
    logic                          take;
    logic [DATA_WIDTH-3:0]         trail_hi;

    for (genvar i = 0; i < NUM_TAPS; i++) begin : g_coef
        assign h[i] = COEFS[i*COEF_WIDTH +: COEF_WIDTH];
    end

    assign out_free = !data_output_valid || data_output_ready;
    assign take = (state == IDLE) || (state == HEADER) || (state == PAYLOAD);
    assign data_input_ready = reset_n && live && out_free && take;
    assign accept = data_input_valid && data_input_ready;
    assign trail_hi = data_input_data[DATA_WIDTH-1:2];

    assign prod = PRW'(x[k]) * PRW'(h[k]);
    assign shifted = acc >>> FRAC_BITS;

    // Scale the accumulator down and clip it into the sample range
    always_comb begin
        clip = 1'b0;
        result = shifted[DATA_WIDTH-1:0];
        if (shifted > SMAX) begin
            clip = 1'b1;
            result = SMAX[DATA_WIDTH-1:0];
        end else if (shifted < SMIN) begin
            clip = 1'b1;
            result = SMIN[DATA_WIDTH-1:0];
        end
    end

    // Packet FSM, delay line, MAC and single-entry output register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            live <= 1'b0;
            sat <= 1'b0;
            k <= '0;
            phase <= '0;
            hcnt <= '0;
            acc <= '0;
            for (int i = 0; i < NUM_TAPS; i++) x[i] <= '0;
            data_output_valid <= 1'b0;
            data_output_startofpacket <= 1'b0;
            data_output_endofpacket <= 1'b0;
            data_output_data <= '0;
        end else begin
            live <= 1'b1;
            if (data_output_ready) data_output_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept && data_input_startofpacket) begin
                        data_output_valid <= 1'b1;
                        data_output_startofpacket <= 1'b1;
                        data_output_endofpacket <= data_input_endofpacket;
                        data_output_data <= data_input_data;
                        for (int i = 0; i < NUM_TAPS; i++) x[i] <= '0;
                        phase <= '0;
                        sat <= 1'b0;
                        hcnt <= HW'(1);
                        if (data_input_endofpacket) state <= IDLE;
                        else if (HEADER_WORDS == 1) state <= PAYLOAD;
                        else state <= HEADER;
                    end
                end
                HEADER: begin
                    if (accept) begin
                        data_output_valid <= 1'b1;
                        data_output_startofpacket <= 1'b0;
                        if (data_input_endofpacket) begin
                            data_output_endofpacket <= 1'b1;
                            data_output_data <= {trail_hi, sat, 1'b1};
                            state <= IDLE;
                        end else begin
                            data_output_endofpacket <= 1'b0;
                            data_output_data <= data_input_data;
                            hcnt <= hcnt + HW'(1);
                            if (hcnt == HW'(HEADER_WORDS - 1)) state <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        if (data_input_endofpacket) begin
                            data_output_valid <= 1'b1;
                            data_output_startofpacket <= 1'b0;
                            data_output_endofpacket <= 1'b1;
                            data_output_data <= {trail_hi, sat, 1'b0};
                            state <= IDLE;
                        end else begin
                            x[0] <= data_input_data;
                            for (int i = 1; i < NUM_TAPS; i++) x[i] <= x[i-1];
                            if (phase == PW'(DECIM - 1)) begin
                                phase <= '0;
                                acc <= '0;
                                k <= '0;
                                state <= MAC;
                            end else begin
                                phase <= phase + PW'(1);
                            end
                        end
                    end
                end
                MAC: begin
                    acc <= acc + ACW'(prod);
                    if (k == KW'(NUM_TAPS - 1)) state <= EMIT;
                    else k <= k + KW'(1);
                end
                EMIT: begin
                    if (out_free) begin
                        data_output_valid <= 1'b1;
                        data_output_startofpacket <= 1'b0;
                        data_output_endofpacket <= 1'b0;
                        data_output_data <= result;
                        sat <= sat | clip;
                        state <= PAYLOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_avl_decim.sv
// Scoreboard bench for fir_avl_decim: two instances (0.25 and 1.0 taps)
// share one stimulus bus; a monitor pops expected beats as outputs appear.
module tb_fir_avl_decim;
    localparam int DW = 16;
    localparam int CW = 18;
    localparam int NT = 4;
    localparam logic [NT*CW-1:0] CA = {NT{18'h04000}};
    localparam logic [NT*CW-1:0] CB = {NT{18'h10000}};

    typedef struct packed {
        logic          v;
        logic          sop;
        logic          eop;
        logic [DW-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_sop = 1'b0;
    logic in_eop = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic sel = 1'b0;
    logic out_ready = 1'b1;
    logic bp = 1'b0;
    logic exp_rdy = 1'b0;
    logic rdy_a, rdy_b, v_a, v_b, s_a, s_b, e_a, e_b;
    logic [DW-1:0] d_a, d_b;

    beat_t qa[$];
    beat_t qb[$];
    int vectors = 0;
    int errs = 0;
    int tmo_cnt = 0, tmo_seen = 0;
    int rst_req = 0, rst_done = 0;
    int rdy_req = 0, rdy_done = 0;
    int fin_req = 0, fin_done = 0;
    int bp_cnt = 0;

    always #5 clk = ~clk;

    fir_avl_decim #(
        .DATA_WIDTH(DW), .COEF_WIDTH(CW), .FRAC_BITS(16),
        .NUM_TAPS(NT), .DECIM(2), .HEADER_WORDS(3), .COEFS(CA)
    ) dut_a (
        .clk(clk), .reset_n(reset_n),
        .data_input_ready(rdy_a),
        .data_input_valid(in_valid & ~sel),
        .data_input_startofpacket(in_sop),
        .data_input_endofpacket(in_eop),
        .data_input_data(in_data),
        .data_output_ready(out_ready),
        .data_output_valid(v_a),
        .data_output_startofpacket(s_a),
        .data_output_endofpacket(e_a),
        .data_output_data(d_a)
    );

    fir_avl_decim #(
        .DATA_WIDTH(DW), .COEF_WIDTH(CW), .FRAC_BITS(16),
        .NUM_TAPS(NT), .DECIM(2), .HEADER_WORDS(3), .COEFS(CB)
    ) dut_b (
        .clk(clk), .reset_n(reset_n),
        .data_input_ready(rdy_b),
        .data_input_valid(in_valid & sel),
        .data_input_startofpacket(in_sop),
        .data_input_endofpacket(in_eop),
        .data_input_data(in_data),
        .data_output_ready(out_ready),
        .data_output_valid(v_b),
        .data_output_startofpacket(s_b),
        .data_output_endofpacket(e_b),
        .data_output_data(d_b)
    );

    // Downstream ready: high one cycle in three while back-pressure is on
    always @(posedge clk) begin
        #1;
        bp_cnt = (bp_cnt + 1) % 3;
        out_ready = bp ? (bp_cnt == 0) : 1'b1;
    end

    function automatic void chk(string nm, int act, int exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endfunction

    beat_t act_a, act_b, hold_a, hold_b;
    bit st_a = 1'b0;
    bit st_b = 1'b0;

    // Monitor: all comparisons happen here, on the falling edge
    always @(negedge clk) begin
        act_a = '{v: v_a, sop: s_a, eop: e_a, data: d_a};
        act_b = '{v: v_b, sop: s_b, eop: e_b, data: d_b};
        while (tmo_seen != tmo_cnt) begin
            tmo_seen++;
            vectors++;
            errs++;
        end
        if (rst_req != rst_done) begin
            rst_done = rst_req;
            chk("rst_out_a", int'(act_a), 0);
            chk("rst_out_b", int'(act_b), 0);
            chk("rst_rdy_a", int'(rdy_a), 0);
            chk("rst_rdy_b", int'(rdy_b), 0);
        end
        if (rdy_req != rdy_done) begin
            rdy_done = rdy_req;
            chk("rdy_a", int'(rdy_a), int'(exp_rdy));
        end
        if (st_a) chk("hold_a", int'(act_a), int'(hold_a));
        if (st_b) chk("hold_b", int'(act_b), int'(hold_b));
        if (v_a === 1'b1 && out_ready) begin
            if (qa.size() == 0) begin
                vectors++;
                errs++;
                $display("FAIL extra_a got %h want none", act_a);
            end else begin
                chk("out_a", int'(act_a), int'(qa.pop_front()));
            end
        end
        if (v_b === 1'b1 && out_ready) begin
            if (qb.size() == 0) begin
                vectors++;
                errs++;
                $display("FAIL extra_b got %h want none", act_b);
            end else begin
                chk("out_b", int'(act_b), int'(qb.pop_front()));
            end
        end
        st_a = (v_a === 1'b1) && !out_ready;
        st_b = (v_b === 1'b1) && !out_ready;
        hold_a = act_a;
        hold_b = act_b;
        if (fin_req != fin_done) begin
            fin_done = fin_req;
            chk("left_a", qa.size(), 0);
            chk("left_b", qb.size(), 0);
        end
    end

    function automatic void ex(logic s, logic e, logic [DW-1:0] d);
        beat_t b;
        b = '{v: 1'b1, sop: s, eop: e, data: d};
        if (sel) qb.push_back(b);
        else qa.push_back(b);
    endfunction

    task automatic send(input logic s, input logic e, input logic [DW-1:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_sop = s;
        in_eop = e;
        in_data = d;
        @(negedge clk);
        while (!(sel ? rdy_b : rdy_a) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            $display("FAIL send_timeout got ready=0 want ready=1 word %h", d);
            tmo_cnt++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sop = 1'b0;
        in_eop = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (n >= 500) begin
            $display("FAIL drain_timeout got %0d/%0d want 0/0", qa.size(), qb.size());
            tmo_cnt++;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic ex_hdr();
        ex(1'b1, 1'b0, 16'hA001);
        ex(1'b0, 1'b0, 16'h0002);
        ex(1'b0, 1'b0, 16'h0003);
    endtask

    task automatic send_hdr();
        send(1'b1, 1'b0, 16'hA001);
        send(1'b0, 1'b0, 16'h0002);
        send(1'b0, 1'b0, 16'h0003);
    endtask

    task automatic const_pkt(input logic [DW-1:0] first, input logic [DW-1:0] rest);
        ex_hdr();
        ex(1'b0, 1'b0, first);
        repeat (3) ex(1'b0, 1'b0, rest);
        ex(1'b0, 1'b1, 16'h1234);
        send_hdr();
        repeat (8) send(1'b0, 1'b0, 16'h1000);
        send(1'b0, 1'b1, 16'h1234);
        drain();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_req++;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_rdy = 1'b0;
        rdy_req++;
        @(posedge clk);
        #1;
        exp_rdy = 1'b1;
        rdy_req++;
        @(posedge clk);
        #1;

        sel = 1'b0;
        send(1'b0, 1'b0, 16'h5A5A);
        const_pkt(16'h0800, 16'h1000);

        sel = 1'b1;
        ex_hdr();
        ex(1'b0, 1'b0, 16'h7FFF);
        ex(1'b0, 1'b0, 16'h7FFF);
        ex(1'b0, 1'b1, 16'h1236);
        send_hdr();
        repeat (4) send(1'b0, 1'b0, 16'h7FFF);
        send(1'b0, 1'b1, 16'h1234);
        drain();
        const_pkt(16'h2000, 16'h4000);

        sel = 1'b0;
        ex(1'b1, 1'b0, 16'hA001);
        ex(1'b0, 1'b1, 16'hFFFD);
        send(1'b1, 1'b0, 16'hA001);
        send(1'b0, 1'b1, 16'hFFFC);
        drain();

        bp = 1'b1;
        const_pkt(16'h0800, 16'h1000);
        bp = 1'b0;
        drain();

        ex_hdr();
        ex(1'b0, 1'b0, 16'h0300);
        ex(1'b0, 1'b0, 16'h0A00);
        ex(1'b0, 1'b1, 16'h00F0);
        send_hdr();
        send(1'b0, 1'b0, 16'h0400);
        send(1'b0, 1'b0, 16'h0800);
        send(1'b0, 1'b0, 16'h0C00);
        send(1'b0, 1'b0, 16'h1000);
        send(1'b0, 1'b0, 16'h1400);
        send(1'b0, 1'b1, 16'h00F0);
        drain();

        ex_hdr();
        ex(1'b0, 1'b0, 16'hFFFF);
        ex(1'b0, 1'b1, 16'h0000);
        send_hdr();
        send(1'b0, 1'b0, 16'hFFFF);
        send(1'b0, 1'b0, 16'hFFFF);
        send(1'b0, 1'b1, 16'h0003);
        drain();

        ex_hdr();
        ex(1'b0, 1'b1, 16'h5550);
        send_hdr();
        send(1'b0, 1'b1, 16'h5550);
        drain();

        ex(1'b1, 1'b1, 16'hBEE4);
        send(1'b1, 1'b1, 16'hBEE4);
        drain();

        ex_hdr();
        ex(1'b0, 1'b0, 16'h0800);
        send_hdr();
        send(1'b0, 1'b0, 16'h1000);
        send(1'b0, 1'b0, 16'h1000);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        qa.delete();
        reset_n = 1'b1;
        rst_req++;
        @(posedge clk);
        #1;
        const_pkt(16'h0800, 16'h1000);

        fin_req++;
        @(negedge clk);
        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
